seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100000, SHALL set the sysclk cycles per digit slot (BLANK plus SHOW); legal range SCAN_DIV > BLANK_CYC.
REQ-002 Parameter BLANK_CYC, default 16, SHALL set the anti-ghosting blank cycles at the start of each slot; legal range >= 1.
REQ-003 sysclk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 wr_en  in  1  write request from the CPU MMIO decode.
REQ-006 wr_addr  in  2  register select: 0 DIGITS, 1 DOT, 2 ENABLE, 3 reserved.
REQ-007 wr_data  in  32  write data.
REQ-008 wr_ready  out  1  write accept; a write is taken on a cycle with wr_en=1 and wr_ready=1.
REQ-009 Seg  out  7  cathodes a..g, active-low.
REQ-010 Dot  out  1  decimal-point cathode, active-low.
REQ-011 Sel  out  4  digit anodes, active-low, at most one low at a time.

Function
REQ-012 Shadow registers SHALL be: DIGITS = wr_data[15:0] (4 hex nibbles, nibble k drives digit k), DOT = wr_data[3:0], ENABLE = wr_data[3:0]; unused bits are ignored.
REQ-013 Any accepted write, including addr 3, SHALL set the pending flag; addr 3 SHALL change no register.
REQ-014 wr_ready SHALL equal !pending, registered, with no combinational path from wr_en.
REQ-015 Active registers SHALL load the full shadow set, and pending SHALL clear, only at the frame boundary: the last SHOW cycle of digit 3.
REQ-016 The FSM SHALL have states BLANK and SHOW, a 2-bit digit index, and a slot counter that runs 0..SCAN_DIV-1 and then wraps to 0.
REQ-017 BLANK (counter < BLANK_CYC) SHALL drive Sel=4'hF, Seg=7'h7F and Dot=1.
REQ-018 SHOW (counter >= BLANK_CYC) SHALL drive Sel bit k = 0 for the current digit k only if ENABLE[k]=1, Seg = hex decode of nibble k, and Dot = !DOT[k].
REQ-019 A disabled digit SHALL keep Sel=4'hF, Seg=7'h7F and Dot=1 for its whole slot, and SHALL still consume its slot time.
REQ-020 On counter wrap the digit index SHALL increment modulo 4 (3 -> 0) and the state SHALL return to BLANK.
REQ-021 Seg, Dot and Sel SHALL be registered outputs, lagging the state/counter by exactly 1 cycle.
REQ-022 The frame period SHALL be exactly 4*SCAN_DIV cycles.
REQ-023 Hex decode SHALL cover all 16 values 0-F (seven-segment patterns for 0-9, A, b, C, d, E, F).
REQ-024 A wr_en=1 while wr_ready=0 SHALL be ignored, with no state change.
REQ-025 A commit cycle SHALL drive wr_ready=1 on the following cycle.

Reset
REQ-026 Reset SHALL set the following, asynchronously on rst low: active and shadow DIGITS=16'h0000, DOT=4'h0, ENABLE=4'hF; pending=0; wr_ready=1; state=BLANK; digit=0; counter=0; Seg=7'h7F; Dot=1; Sel=4'hF.
REQ-027 Reset asserted mid-frame SHALL discard pending writes and blank the display within the same asynchronous assertion.
REQ-028 After release, the display SHALL show "0000" starting at cycle BLANK_CYC+1.

Structure
REQ-029 A shared package seg_defs SHALL hold the register address constants, the 16-entry segment pattern table, and the blank constants (7'h7F, 4'hF).
REQ-030 Hex decode SHALL be a separate combinational sub-module seg_hex_decoder (4-bit in, 7-bit active-low out).
REQ-031 The implementation SHALL be roughly 150-250 RTL lines, with the FSM, counter and register file in seg_scan_ctrl.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-032 Scenario 1: release reset, run one frame -> each digit k shows Sel low only on bit k for 6 cycles, Seg=7'h40 ("0"), and Sel=4'hF for 2 cycles between digits.
REQ-033 Scenario 2: write addr 0 data 32'h0000_A1F3 mid-frame -> wr_ready=0 until the boundary, old digits persist until then, and the next frame shows 3, F, 1, A on digits 0..3.
REQ-034 Scenario 3: write ENABLE=4'b0101 and DOT=4'b0001 (second write issued after the commit) -> only digits 0 and 2 are lit and Dot=0 only on digit 0; frame period stays 32 cycles.
REQ-035 Scenario 4: hold wr_en=1 with a changing wr_data while pending -> only the first write is committed.
REQ-036 Scenario 5: assert rst during SHOW of digit 2 with a write pending -> outputs blank immediately, and after release the display shows "0000" with all digits enabled.
REQ-037 Scenario 6: write addr 3 -> pending sets and clears at the boundary, with no visible change.

Source files
------------

// File: rtl/seg_defs.sv
// Shared constants for the 4-digit seven-segment scan controller:
// register map, segment table, blank levels and the register-set type.
package seg_defs;

  localparam logic [1:0] ADDR_DIGITS = 2'd0;
  localparam logic [1:0] ADDR_DOT    = 2'd1;
  localparam logic [1:0] ADDR_ENABLE = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] SEL_BLANK = 4'hF;

  // Active-low {g,f,e,d,c,b,a}, entry 15 leftmost
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_e;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dot;
    logic [3:0]  en;
  } disp_regs_t;

  localparam disp_regs_t REGS_RST = '{
    digits: 16'h0000,
    dot:    4'h0,
    en:     4'hF
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decoder
  import seg_defs::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nib];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit display scanner with MMIO shadow registers
// that commit to the active set only at the end of each frame.
module seg_scan_ctrl
  import seg_defs::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic [6:0]  Seg,
  output logic        Dot,
  output logic [3:0]  Sel
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);

  scan_state_e state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;

  disp_regs_t shadow_q, shadow_d;
  disp_regs_t active_q, active_d;
  logic pending_q, pending_d;
  logic ready_q, ready_d;

  logic [6:0] seg_q, seg_d;
  logic       dot_q, dot_d;
  logic [3:0] sel_q, sel_d;

  logic cnt_wrap;
  logic frame_end;
  logic wr_take;
  logic [3:0] nib;
  logic [6:0] hex_seg;

  always_comb begin
    cnt_wrap  = (cnt_q == CNT_LAST);
    frame_end = cnt_wrap && (digit_q == 2'd3)
                && (state_q == ST_SHOW);
    wr_take   = wr_en && ready_q;
  end

  always_comb begin
    cnt_d   = cnt_wrap ? '0 : cnt_q + 1'b1;
    digit_d = cnt_wrap ? digit_q + 2'd1 : digit_q;
    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if (cnt_d >= CNT_SHOW) state_d = ST_SHOW;
      ST_SHOW:  if (cnt_wrap) state_d = ST_BLANK;
    endcase
  end

  // A write landing on the boundary cycle commits one frame later
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frame_end) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_take) begin
      pending_d = 1'b1;
      unique case (1'b1)
        (wr_addr == ADDR_DIGITS): shadow_d.digits = wr_data[15:0];
        (wr_addr == ADDR_DOT):    shadow_d.dot    = wr_data[3:0];
        (wr_addr == ADDR_ENABLE): shadow_d.en     = wr_data[3:0];
        default: ;
      endcase
    end
    ready_d = !pending_d;
  end

  always_comb begin
    nib = active_q.digits[{digit_q, 2'b00} +: 4];
  end

  seg_hex_decoder u_dec (
    .nib (nib),
    .seg (hex_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    dot_d = 1'b1;
    sel_d = SEL_BLANK;
    if (state_q == ST_SHOW && active_q.en[digit_q]) begin
      sel_d = ~(4'b0001 << digit_q);
      seg_d = hex_seg;
      dot_d = ~active_q.dot[digit_q];
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_BLANK;
      digit_q   <= 2'd0;
      cnt_q     <= '0;
      shadow_q  <= REGS_RST;
      active_q  <= REGS_RST;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      seg_q     <= SEG_BLANK;
      dot_q     <= 1'b1;
      sel_q     <= SEL_BLANK;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      seg_q     <= seg_d;
      dot_q     <= dot_d;
      sel_q     <= sel_d;
    end
  end

  assign wr_ready = ready_q;
  assign Seg      = seg_q;
  assign Dot      = dot_q;
  assign Sel      = sel_q;

endmodule
